fft_frame_sequencer: RTL and testbench

Initiator-side companion to `fft_controller`. It collects a serial stream of signed samples into an `FFT_POINTS` frame and presents that frame on the controller's parallel input arrays. It then issues the start pulse, captures the parallel result when `fft_data_valid` rises, and re-serialises the result as a ready/valid stream. It sits between the audio sample path and the FFT in the convolution datapath, and one instance serves forward or inverse transforms per frame.

---
 rtl/fft_frame_sequencer.sv | 159 +++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// =====================================================================
// Module : fft_frame_sequencer
// Brief  : Frames a serial sample stream for fft_controller, issues the
//          start pulse and re-serialises the result as a ready/valid stream.
//          Define FFT_SEQ_ZERO_PAD_EN to fill half a frame and zero the rest.
// Rev    : 1.0  initial release
// =====================================================================
`default_nettype none

module fft_frame_sequencer #(
    parameter int FFT_POINTS = 16,
    parameter int DATA_WIDTH = 24,
    parameter int OUT_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            in_sample,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_dir,
    output logic                             start_fft,
    output logic                             forward_inverse,
    output logic [DATA_WIDTH*FFT_POINTS-1:0] fft_in_real,
    output logic [DATA_WIDTH*FFT_POINTS-1:0] fft_in_imag,
    input  logic [OUT_WIDTH*FFT_POINTS-1:0]  fft_out_real,
    input  logic [OUT_WIDTH*FFT_POINTS-1:0]  fft_out_imag,
    input  logic                             fft_data_valid,
    input  logic                             fft_in_prog,
    output logic [OUT_WIDTH-1:0]             out_real,
    output logic [OUT_WIDTH-1:0]             out_imag,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             drop_sticky
);

`ifdef FFT_SEQ_ZERO_PAD_EN
    localparam int c_FILL_COUNT = FFT_POINTS / 2;
`else
    localparam int c_FILL_COUNT = FFT_POINTS;
`endif
    localparam int c_IDX_W = $clog2(FFT_POINTS);
    localparam int c_WR_W  = $clog2(c_FILL_COUNT);

    localparam logic [1:0] c_ST_FILL  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    logic [1:0]            r_state;
    logic [c_WR_W-1:0]     r_wr_idx;
    logic [c_IDX_W-1:0]    r_rd_idx;
    logic [DATA_WIDTH-1:0] r_in_buf  [c_FILL_COUNT];
    logic [OUT_WIDTH-1:0]  r_out_re  [FFT_POINTS];
    logic [OUT_WIDTH-1:0]  r_out_im  [FFT_POINTS];
    logic                  r_fwd_inv;
    logic                  r_drop;

    logic w_in_ready;
    logic w_accept;
    logic w_last_accept;
    logic w_out_fire;
    logic w_last_beat;

    // Gating with reset keeps in_ready low while reset is held.
    assign w_in_ready    = (r_state == c_ST_FILL) && !reset;
    assign w_accept      = in_valid && w_in_ready;
    assign w_last_accept = w_accept && (r_wr_idx == c_WR_W'(c_FILL_COUNT - 1));
    assign w_out_fire    = (r_state == c_ST_DRAIN) && out_ready;
    assign w_last_beat   = (r_rd_idx == c_IDX_W'(FFT_POINTS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_FILL;
            r_wr_idx  <= '0;
            r_rd_idx  <= '0;
            r_fwd_inv <= 1'b0;
            r_drop    <= 1'b0;
            for (int i = 0; i < c_FILL_COUNT; i++) begin
                r_in_buf[i] <= '0;
            end
            for (int i = 0; i < FFT_POINTS; i++) begin
                r_out_re[i] <= '0;
                r_out_im[i] <= '0;
            end
        end else begin
            if (in_valid && !w_in_ready) begin
                r_drop <= 1'b1;
            end
            case (r_state)
                c_ST_FILL: begin
                    if (w_accept) begin
                        r_in_buf[r_wr_idx] <= in_sample;
                        if (r_wr_idx == '0) begin
                            r_fwd_inv <= in_dir;
                        end
                        if (w_last_accept) begin
                            r_wr_idx <= '0;
                            r_state  <= c_ST_START;
                        end else begin
                            r_wr_idx <= r_wr_idx + 1'b1;
                        end
                    end
                end
                c_ST_START: begin
                    if (!fft_in_prog) begin
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (fft_data_valid) begin
                        for (int i = 0; i < FFT_POINTS; i++) begin
                            r_out_re[i] <= fft_out_real[i*OUT_WIDTH +: OUT_WIDTH];
                            r_out_im[i] <= fft_out_imag[i*OUT_WIDTH +: OUT_WIDTH];
                        end
                        r_rd_idx <= '0;
                        r_state  <= c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    if (w_out_fire) begin
                        if (w_last_beat) begin
                            r_rd_idx <= '0;
                            r_state  <= c_ST_FILL;
                        end else begin
                            r_rd_idx <= r_rd_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= c_ST_FILL;
            endcase
        end
    end

    // Entries past the fill count never see a write, so they read as zero.
    genvar g;
    generate
        for (g = 0; g < FFT_POINTS; g++) begin : g_in_map
            if (g < c_FILL_COUNT) begin : g_live
                assign fft_in_real[g*DATA_WIDTH +: DATA_WIDTH] = r_in_buf[g];
            end else begin : g_pad
                assign fft_in_real[g*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    endgenerate

    assign fft_in_imag     = '0;
    assign in_ready        = w_in_ready;
    assign start_fft       = (r_state == c_ST_START) && !fft_in_prog;
    assign forward_inverse = r_fwd_inv;
    assign out_valid       = (r_state == c_ST_DRAIN);
    assign out_last        = out_valid && w_last_beat;
    assign out_real        = out_valid ? r_out_re[r_rd_idx] : '0;
    assign out_imag        = out_valid ? r_out_im[r_rd_idx] : '0;
    assign drop_sticky     = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
// =====================================================================
// Module : tb_fft_frame_sequencer
// Brief  : Self-checking bench for fft_frame_sequencer with a behavioural
//          controller and a frame-level reference model.
// Rev    : 1.0  initial release
// =====================================================================
`default_nettype none

module tb_fft_frame_sequencer;

    localparam int N  = 16;
    localparam int DW = 24;
    localparam int OW = 32;
`ifdef FFT_SEQ_ZERO_PAD_EN
    localparam int FILL = N / 2;
`else
    localparam int FILL = N;
`endif

    logic          clk;
    logic          reset;
    logic [DW-1:0] in_sample;
    logic          in_valid;
    logic          in_ready;
    logic          in_dir;
    logic          start_fft;
    logic          forward_inverse;
    logic [DW*N-1:0] fft_in_real;
    logic [DW*N-1:0] fft_in_imag;
    logic [OW*N-1:0] fft_out_real;
    logic [OW*N-1:0] fft_out_imag;
    logic          fft_data_valid;
    logic          fft_in_prog;
    logic [OW-1:0] out_real;
    logic [OW-1:0] out_imag;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          drop_sticky;

    fft_frame_sequencer #(
        .FFT_POINTS (N),
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_sample       (in_sample),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_dir          (in_dir),
        .start_fft       (start_fft),
        .forward_inverse (forward_inverse),
        .fft_in_real     (fft_in_real),
        .fft_in_imag     (fft_in_imag),
        .fft_out_real    (fft_out_real),
        .fft_out_imag    (fft_out_imag),
        .fft_data_valid  (fft_data_valid),
        .fft_in_prog     (fft_in_prog),
        .out_real        (out_real),
        .out_imag        (out_imag),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .drop_sticky     (drop_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            vectors = 0;
    int            errors  = 0;
    logic          exp_drop = 1'b0;
    logic [DW-1:0] smp [N];

    localparam int READY_ALWAYS  = 0;
    localparam int READY_PATTERN = 1;
    localparam int READY_RANDOM  = 2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full frame: fill, start, controller echo, drain. abort_beat >= 0
    // pulses reset when the drain reaches that beat.
    task automatic do_frame(input logic dir, input bit busy_before, input int ready_mode,
                            input bit hold_in_valid, input int abort_beat);
        logic [DW-1:0]   model_in [N];
        logic [OW-1:0]   cap_re [N];
        logic [OW-1:0]   cap_im [N];
        logic [DW*N-1:0] exp_flat;
        logic            rdy;
        int              k;
        int              cyc;
        int              pat [4];
        pat = '{1, 0, 0, 1};

        for (int i = 0; i < N; i++) begin
            model_in[i] = (i < FILL) ? smp[i] : '0;
            exp_flat[i*DW +: DW] = model_in[i];
            cap_re[i] = {{(OW-DW){model_in[i][DW-1]}}, model_in[i]};
            cap_im[i] = OW'($urandom());
        end

        fft_in_prog = busy_before;
        for (int i = 0; i < FILL; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                tick();
            end
            in_sample = smp[i];
            in_valid  = 1'b1;
            in_dir    = (i == 0) ? dir : ~dir;
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready[%0d]: got %b want 1", i, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        in_dir   = ~dir;

        if (busy_before) begin
            for (int c = 0; c < 3; c++) begin
                vectors++;
                if (start_fft !== 1'b0) begin
                    errors++;
                    $display("FAIL start_while_busy: got %b want 0", start_fft);
                end
                tick();
            end
            fft_in_prog = 1'b0;
            #1;
        end

        vectors++;
        if (start_fft !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse: got %b want 1", start_fft);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_start: got %b want 0", in_ready);
        end
        vectors++;
        if (forward_inverse !== dir) begin
            errors++;
            $display("FAIL fwd_inv: got %b want %b", forward_inverse, dir);
        end
        vectors++;
        if (fft_in_real !== exp_flat) begin
            errors++;
            $display("FAIL frame_buf: got %h want %h", fft_in_real, exp_flat);
        end
        vectors++;
        if (fft_in_imag !== '0) begin
            errors++;
            $display("FAIL imag_zero: got %h want 0", fft_in_imag);
        end

        tick();
        vectors++;
        if (start_fft !== 1'b0) begin
            errors++;
            $display("FAIL start_single: got %b want 0", start_fft);
        end

        fft_in_prog = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (hold_in_valid) begin
                in_valid  = 1'b1;
                in_sample = DW'($urandom());
            end
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL wait_idle: got valid %b ready %b want 0 0", out_valid, in_ready);
            end
            tick();
            if (hold_in_valid) begin
                exp_drop = 1'b1;
                vectors++;
                if (drop_sticky !== 1'b1) begin
                    errors++;
                    $display("FAIL drop_set: got %b want 1", drop_sticky);
                end
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (fft_in_real !== exp_flat || forward_inverse !== dir) begin
            errors++;
            $display("FAIL wait_hold: got %h/%b want %h/%b", fft_in_real, forward_inverse, exp_flat, dir);
        end

        for (int i = 0; i < N; i++) begin
            fft_out_real[i*OW +: OW] = cap_re[i];
            fft_out_imag[i*OW +: OW] = cap_im[i];
        end
        fft_in_prog    = 1'b0;
        fft_data_valid = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_early: got %b want 0", out_valid);
        end
        tick();
        fft_data_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            fft_out_real[i*OW +: OW] = OW'($urandom());
            fft_out_imag[i*OW +: OW] = OW'($urandom());
        end

        k   = 0;
        cyc = 0;
        while (k < N && cyc < 200) begin
            case (ready_mode)
                READY_PATTERN: rdy = pat[cyc % 4] != 0;
                READY_RANDOM:  rdy = $urandom_range(0, 1) != 0;
                default:       rdy = 1'b1;
            endcase
            out_ready = rdy;
            if (k == abort_beat) begin
                reset     = 1'b1;
                out_ready = 1'b0;
                tick();
                exp_drop = 1'b0;
                vectors++;
                if (out_valid !== 1'b0 || drop_sticky !== 1'b0 || start_fft !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_reset: got valid %b drop %b start %b want 0 0 0",
                             out_valid, drop_sticky, start_fft);
                end
                vectors++;
                if (fft_in_real !== '0 || forward_inverse !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_clear: got %h/%b want 0/0", fft_in_real, forward_inverse);
                end
                reset = 1'b0;
                #1;
                vectors++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_ready: got %b want 1", in_ready);
                end
                return;
            end
            #1;
            vectors++;
            if (out_valid !== 1'b1 || out_real !== cap_re[k] || out_imag !== cap_im[k]) begin
                errors++;
                $display("FAIL drain[%0d]: got %b %h %h want 1 %h %h",
                         k, out_valid, out_real, out_imag, cap_re[k], cap_im[k]);
            end
            vectors++;
            if (out_last !== (k == N - 1)) begin
                errors++;
                $display("FAIL last[%0d]: got %b want %b", k, out_last, (k == N - 1));
            end
            if (rdy) k++;
            cyc++;
            tick();
        end
        out_ready = 1'b0;
        vectors++;
        if (k != N) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats want %0d", k, N);
        end
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_drain: got valid %b last %b ready %b want 0 0 1",
                     out_valid, out_last, in_ready);
        end
        vectors++;
        if (drop_sticky !== exp_drop) begin
            errors++;
            $display("FAIL drop_state: got %b want %b", drop_sticky, exp_drop);
        end
    endtask

    task automatic randomize_samples();
        for (int i = 0; i < N; i++) smp[i] = DW'($urandom());
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (in_ready !== 1'b0 || start_fft !== 1'b0 || forward_inverse !== 1'b0 ||
            out_valid !== 1'b0 || out_last !== 1'b0 || drop_sticky !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy %b st %b fi %b ov %b ol %b drop %b want all 0",
                     in_ready, start_fft, forward_inverse, out_valid, out_last, drop_sticky);
        end
        vectors++;
        if (out_real !== '0 || out_imag !== '0 || fft_in_real !== '0 || fft_in_imag !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h want 0", out_real, out_imag, fft_in_real);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_alternating();
        for (int i = 0; i < N; i++) smp[i] = ((i / 2) % 2 == 0) ? 24'h400000 : 24'hC00000;
        do_frame(1'b1, 1'b0, READY_ALWAYS, 1'b0, -1);
    endtask

    task automatic test_stall();
        randomize_samples();
        do_frame(1'b0, 1'b0, READY_PATTERN, 1'b0, -1);
    endtask

    task automatic test_busy_start();
        randomize_samples();
        do_frame(1'b1, 1'b1, READY_RANDOM, 1'b0, -1);
    endtask

    task automatic test_drop_and_reset();
        randomize_samples();
        do_frame(1'b0, 1'b0, READY_ALWAYS, 1'b1, 5);
        randomize_samples();
        do_frame(1'b1, 1'b0, READY_ALWAYS, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            randomize_samples();
            do_frame(1'($urandom_range(0, 1)), 1'b0, READY_RANDOM, 1'b0, -1);
        end
    endtask

`ifdef FFT_SEQ_ZERO_PAD_EN
    task automatic test_zero_pad();
        for (int i = 0; i < N; i++) smp[i] = 24'h123456;
        do_frame(1'b0, 1'b0, READY_ALWAYS, 1'b0, -1);
    endtask
`endif

    initial begin
        reset          = 1'b1;
        in_sample      = '0;
        in_valid       = 1'b0;
        in_dir         = 1'b0;
        fft_out_real   = '0;
        fft_out_imag   = '0;
        fft_data_valid = 1'b0;
        fft_in_prog    = 1'b0;
        out_ready      = 1'b0;

        test_reset();
        test_alternating();
        test_stall();
        test_busy_start();
        test_drop_and_reset();
        test_back_to_back();
`ifdef FFT_SEQ_ZERO_PAD_EN
        test_zero_pad();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
